// File: rtl/cpu_pkg.sv
// Shared CPU types: physical tag / architectural register widths and the reserved zero tag.
package cpu_pkg;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_TAGS      = 64;
  localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
  localparam int ARCH_LOG2     = $clog2(NUM_ARCH_REGS);

  typedef logic [NUM_TAGS_LOG2-1:0] tag_t;
  typedef logic [ARCH_LOG2-1:0]     arch_reg_t;
  typedef logic [NUM_TAGS-1:0]      free_vec_t;

  localparam tag_t TAG_ZERO = '0;
endpackage

// File: rtl/rename_stage_if.sv
// Decode -> rename -> issue-queue bundle plus the ROB retire port.
// RENAME_FLUSH_EN adds the flush signal.
interface rename_stage_if;
  import cpu_pkg::*;

  logic        in_valid;
  logic [3:0]  in_op;
  arch_reg_t   in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_uses_imm, in_writes_rd;
  logic        stall_in;
  logic        rename_stall;
  logic        out_valid;
  logic [3:0]  op;
  logic [31:0] imm;
  tag_t        tag_rd, tag_rs1, tag_rs2, old_tag_rd;
  logic        retire_valid;
  arch_reg_t   retire_arch_rd;
  tag_t        retire_tag_rd, retire_old_tag;
`ifdef RENAME_FLUSH_EN
  logic        flush;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_uses_imm, in_writes_rd,
    output stall_in, retire_valid, retire_arch_rd, retire_tag_rd, retire_old_tag, flush,
    input  rename_stall, out_valid, op, imm, tag_rd, tag_rs1, tag_rs2, old_tag_rd
  );
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_uses_imm, in_writes_rd,
    input  stall_in, retire_valid, retire_arch_rd, retire_tag_rd, retire_old_tag, flush,
    output rename_stall, out_valid, op, imm, tag_rd, tag_rs1, tag_rs2, old_tag_rd
  );
`else
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_uses_imm, in_writes_rd,
    output stall_in, retire_valid, retire_arch_rd, retire_tag_rd, retire_old_tag,
    input  rename_stall, out_valid, op, imm, tag_rd, tag_rs1, tag_rs2, old_tag_rd
  );
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_uses_imm, in_writes_rd,
    input  stall_in, retire_valid, retire_arch_rd, retire_tag_rd, retire_old_tag,
    output rename_stall, out_valid, op, imm, tag_rd, tag_rs1, tag_rs2, old_tag_rd
  );
`endif
endinterface

// File: rtl/free_list.sv
// Physical tag free vector with lowest-index allocation.
// RENAME_FLUSH_EN adds a flush that reloads the vector from a rebuild input.
module free_list
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      alloc,
  input  logic      free_valid,
  input  tag_t      free_tag,
`ifdef RENAME_FLUSH_EN
  input  logic      flush,
  input  free_vec_t rebuild_vec,
`endif
  output tag_t      alloc_tag,
  output logic      empty
);
  // Tags 0..31 start mapped to the architectural registers.
  localparam free_vec_t RESET_FREE = {{(NUM_TAGS-NUM_ARCH_REGS){1'b1}}, {NUM_ARCH_REGS{1'b0}}};

  free_vec_t free_reg, free_next;

  always_comb begin
    alloc_tag = TAG_ZERO;
    for (int i = NUM_TAGS-1; i >= 0; i--) begin
      if (free_reg[i]) alloc_tag = tag_t'(i);
    end
    empty = ~|free_reg;
  end

  // A tag freed this cycle only becomes allocatable next cycle.
  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_bit
    if (gi == 0) begin : g_zero
      assign free_next[gi] = 1'b0;
    end else begin : g_tag
      assign free_next[gi] = (free_reg[gi] | (free_valid && free_tag == tag_t'(gi)))
                             & ~(alloc && alloc_tag == tag_t'(gi));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_reg <= RESET_FREE;
`ifdef RENAME_FLUSH_EN
    end else if (flush) begin
      free_reg <= rebuild_vec;
`endif
    end else begin
      free_reg <= free_next;
    end
  end
endmodule

// File: rtl/rename_stage.sv
// Register rename stage: speculative RAT, tag allocation and a registered micro-op to the issue queue.
// RENAME_FLUSH_EN adds a committed RAT and flush recovery.
module rename_stage
  import cpu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave bus
);
  tag_t rat_reg [NUM_ARCH_REGS];
  tag_t alloc_tag;
  logic pool_empty, needs_alloc, accept, do_alloc, flush_now, free_valid;

  logic        out_valid_reg;
  logic [3:0]  op_reg;
  logic [31:0] imm_reg;
  tag_t        tag_rd_reg, tag_rs1_reg, tag_rs2_reg, old_tag_rd_reg;

  assign needs_alloc      = bus.in_writes_rd && (bus.in_rd != '0);
  assign bus.rename_stall = bus.stall_in | (bus.in_valid & needs_alloc & pool_empty);
  assign accept           = bus.in_valid & ~bus.rename_stall & ~flush_now;
  assign do_alloc         = accept & needs_alloc;
  assign free_valid       = bus.retire_valid && (bus.retire_old_tag != TAG_ZERO);

`ifdef RENAME_FLUSH_EN
  tag_t      committed_reg  [NUM_ARCH_REGS];
  tag_t      committed_next [NUM_ARCH_REGS];
  free_vec_t referenced, rebuild_vec;

  assign flush_now = bus.flush;

  for (genvar gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_commit
    assign committed_next[gi] = (bus.retire_valid && gi != 0 && bus.retire_arch_rd == arch_reg_t'(gi))
                                ? bus.retire_tag_rd : committed_reg[gi];
    always_ff @(posedge clk) begin
      if (rst) committed_reg[gi] <= tag_t'(gi);
      else     committed_reg[gi] <= committed_next[gi];
    end
  end

  // Everything the committed map does not point at is free again; tag 0 never is.
  always_comb begin
    referenced = '0;
    for (int i = 0; i < NUM_ARCH_REGS; i++) referenced[committed_next[i]] = 1'b1;
    rebuild_vec    = ~referenced;
    rebuild_vec[0] = 1'b0;
  end
`else
  logic unused_retire;
  assign flush_now     = 1'b0;
  assign unused_retire = ^{bus.retire_arch_rd, bus.retire_tag_rd};
`endif

  free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .alloc      (do_alloc),
    .free_valid (free_valid),
    .free_tag   (bus.retire_old_tag),
`ifdef RENAME_FLUSH_EN
    .flush      (flush_now),
    .rebuild_vec(rebuild_vec),
`endif
    .alloc_tag  (alloc_tag),
    .empty      (pool_empty)
  );

  // Entry 0 is never written: needs_alloc excludes rd == 0 and retire skips x0.
  for (genvar gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_rat
    always_ff @(posedge clk) begin
      if (rst) begin
        rat_reg[gi] <= tag_t'(gi);
`ifdef RENAME_FLUSH_EN
      end else if (flush_now) begin
        rat_reg[gi] <= committed_next[gi];
`endif
      end else if (do_alloc && bus.in_rd == arch_reg_t'(gi)) begin
        rat_reg[gi] <= alloc_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      op_reg         <= '0;
      imm_reg        <= '0;
      tag_rd_reg     <= TAG_ZERO;
      tag_rs1_reg    <= TAG_ZERO;
      tag_rs2_reg    <= TAG_ZERO;
      old_tag_rd_reg <= TAG_ZERO;
    end else if (flush_now) begin
      out_valid_reg <= 1'b0;
    end else if (bus.stall_in) begin
      out_valid_reg <= out_valid_reg;
    end else if (accept) begin
      // Sources see the pre-update RAT, so rd == rs returns the old mapping.
      out_valid_reg  <= 1'b1;
      op_reg         <= bus.in_op;
      imm_reg        <= bus.in_imm;
      tag_rs1_reg    <= rat_reg[bus.in_rs1];
      tag_rs2_reg    <= bus.in_uses_imm ? TAG_ZERO : rat_reg[bus.in_rs2];
      tag_rd_reg     <= needs_alloc ? alloc_tag : TAG_ZERO;
      old_tag_rd_reg <= needs_alloc ? rat_reg[bus.in_rd] : TAG_ZERO;
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.op         = op_reg;
  assign bus.imm        = imm_reg;
  assign bus.tag_rd     = tag_rd_reg;
  assign bus.tag_rs1    = tag_rs1_reg;
  assign bus.tag_rs2    = tag_rs2_reg;
  assign bus.old_tag_rd = old_tag_rd_reg;
endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: a reference RAT/free model predicts each renamed micro-op.
module tb_rename_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] imm;
    tag_t        tag_rd, tag_rs1, tag_rs2, old_tag_rd;
  } uop_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_stage_if bus();
  rename_stage dut (.clk(clk), .rst(rst), .bus(bus));

  uop_t      sb[$];
  tag_t      rat_m [NUM_ARCH_REGS];
  free_vec_t free_m;
  int        passed = 0;
  int        total  = 0;

  function automatic uop_t observe();
    return {bus.out_valid, bus.op, bus.imm, bus.tag_rd, bus.tag_rs1, bus.tag_rs2, bus.old_tag_rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH_REGS; i++) rat_m[i] = tag_t'(i);
    free_m = {{(NUM_TAGS-NUM_ARCH_REGS){1'b1}}, {NUM_ARCH_REGS{1'b0}}};
    sb.delete();
  endtask

  task automatic drive(input logic [3:0] op, input int rs1, input int rs2, input int rd,
                       input logic [31:0] imm, input logic uses_imm, input logic writes_rd);
    bus.in_valid     = 1'b1;
    bus.in_op        = op;
    bus.in_rs1       = arch_reg_t'(rs1);
    bus.in_rs2       = arch_reg_t'(rs2);
    bus.in_rd        = arch_reg_t'(rd);
    bus.in_imm       = imm;
    bus.in_uses_imm  = uses_imm;
    bus.in_writes_rd = writes_rd;
  endtask

  // Predict the micro-op for the instruction currently driven, assuming it is accepted at the next edge.
  task automatic expect_accept();
    uop_t e;
    tag_t t;
    e.valid   = 1'b1;
    e.op      = bus.in_op;
    e.imm     = bus.in_imm;
    e.tag_rs1 = rat_m[bus.in_rs1];
    e.tag_rs2 = bus.in_uses_imm ? TAG_ZERO : rat_m[bus.in_rs2];
    if (bus.in_writes_rd && bus.in_rd != '0) begin
      t = TAG_ZERO;
      for (int i = NUM_TAGS-1; i >= 1; i--) if (free_m[i]) t = tag_t'(i);
      e.tag_rd         = t;
      e.old_tag_rd     = rat_m[bus.in_rd];
      rat_m[bus.in_rd] = t;
      free_m[t]        = 1'b0;
    end else begin
      e.tag_rd     = TAG_ZERO;
      e.old_tag_rd = TAG_ZERO;
    end
    sb.push_back(e);
  endtask

  task automatic test_reset();
    uop_t obs;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_imm = '0; bus.in_uses_imm = 1'b0; bus.in_writes_rd = 1'b0; bus.stall_in = 1'b0;
    bus.retire_valid = 1'b0; bus.retire_arch_rd = '0; bus.retire_tag_rd = '0; bus.retire_old_tag = '0;
`ifdef RENAME_FLUSH_EN
    bus.flush = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    model_reset();
    #1;
    obs = observe();
    total++;
    if (obs !== uop_t'(0)) $display("FAIL reset_outputs: got %h want 0", obs);
    else passed++;
    total++;
    if (bus.rename_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.rename_stall);
    else passed++;
    $display("txn reset: out_valid=%b rename_stall=%b", bus.out_valid, bus.rename_stall);
  endtask

  task automatic test_back_to_back();
    uop_t obs, exp;
    string names[3] = '{"add_x3_x1_x2", "add_x4_x3_x3", "addi_x5_x5"};
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(4'h1, 1, 2, 3, 32'h0, 1'b0, 1'b1);
        1: drive(4'h1, 3, 3, 4, 32'h0, 1'b0, 1'b1);
        default: drive(4'h2, 5, 0, 5, 32'hDEADBEEF, 1'b1, 1'b1);
      endcase
      expect_accept();
      tick();
      obs = observe();
      exp = sb.pop_front();
      total++;
      if (obs !== exp) $display("FAIL %s: got %h want %h", names[k], obs, exp);
      else passed++;
      $display("txn %s: rs1=%0d rs2=%0d rd=%0d old=%0d", names[k], obs.tag_rs1, obs.tag_rs2, obs.tag_rd, obs.old_tag_rd);
      // Fixed expectations from first principles after reset.
      case (k)
        0: exp = {1'b1, 4'h1, 32'h0, tag_t'(32), tag_t'(1), tag_t'(2), tag_t'(3)};
        1: exp = {1'b1, 4'h1, 32'h0, tag_t'(33), tag_t'(32), tag_t'(32), tag_t'(4)};
        default: exp = {1'b1, 4'h2, 32'hDEADBEEF, tag_t'(34), tag_t'(5), tag_t'(0), tag_t'(5)};
      endcase
      total++;
      if (obs !== exp) $display("FAIL %s_const: got %h want %h", names[k], obs, exp);
      else passed++;
    end
    bus.in_valid = 1'b0;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL valid_drop: got %b want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_no_alloc();
    uop_t obs, exp;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(4'h3, 3, 4, 0, 32'h11, 1'b0, 1'b1);   // write to x0
        1: drive(4'h5, 1, 2, 7, 32'h22, 1'b0, 1'b0);   // no rd write
        default: drive(4'h6, 7, 7, 7, 32'h33, 1'b0, 1'b1);
      endcase
      expect_accept();
      tick();
      obs = observe();
      exp = sb.pop_front();
      total++;
      if (obs !== exp) $display("FAIL no_alloc_%0d: got %h want %h", k, obs, exp);
      else passed++;
      $display("txn no_alloc_%0d: rd=%0d old=%0d", k, obs.tag_rd, obs.old_tag_rd);
    end
    // Tag 35 is next only if the two non-writing ops consumed nothing.
    total++;
    if (bus.tag_rd !== tag_t'(35) || bus.old_tag_rd !== tag_t'(7))
      $display("FAIL no_alloc_pool: got rd=%0d old=%0d want rd=35 old=7", bus.tag_rd, bus.old_tag_rd);
    else passed++;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_exhaust();
    uop_t obs, exp, last;
    int n = 0;
    while (free_m != '0 && n < NUM_TAGS) begin
      drive(4'h4, n % 32, (n * 7) % 32, 1 + (n % 31), 32'(n), 1'b0, 1'b1);
      expect_accept();
      tick();
      obs = observe();
      exp = sb.pop_front();
      total++;
      if (obs !== exp) $display("FAIL exhaust_%0d: got %h want %h", n, obs, exp);
      else passed++;
      $display("txn exhaust_%0d: rd=%0d old=%0d", n, obs.tag_rd, obs.old_tag_rd);
      n++;
    end
    total++;
    if (n !== 28) $display("FAIL exhaust_count: got %0d want 28", n);
    else passed++;
    last = observe();
    drive(4'h7, 1, 2, 9, 32'h99, 1'b0, 1'b1);
    #1;
    total++;
    if (bus.rename_stall !== 1'b1) $display("FAIL empty_stall: got %b want 1", bus.rename_stall);
    else passed++;
    tick();
    obs = observe();
    last.valid = 1'b0;
    total++;
    if (obs !== last) $display("FAIL empty_hold: got %h want %h", obs, last);
    else passed++;
    // Retire frees tag 3; no same-cycle bypass into the allocator.
    bus.retire_valid = 1'b1; bus.retire_arch_rd = 5'd3; bus.retire_tag_rd = 6'd32; bus.retire_old_tag = 6'd3;
    #1;
    total++;
    if (bus.rename_stall !== 1'b1) $display("FAIL free_no_bypass: got %b want 1", bus.rename_stall);
    else passed++;
    tick();
    free_m[3] = 1'b1;
    bus.retire_valid = 1'b0;
    #1;
    total++;
    if (bus.rename_stall !== 1'b0) $display("FAIL free_release: got %b want 0", bus.rename_stall);
    else passed++;
    expect_accept();
    tick();
    obs = observe();
    exp = sb.pop_front();
    total++;
    if (obs !== exp || obs.tag_rd !== tag_t'(3)) $display("FAIL reuse_tag3: got %h want %h", obs, exp);
    else passed++;
    $display("txn reuse_tag3: rd=%0d old=%0d", obs.tag_rd, obs.old_tag_rd);
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall_in();
    uop_t obs, exp, held;
    bus.retire_valid = 1'b1; bus.retire_old_tag = 6'd4; bus.retire_arch_rd = 5'd4; bus.retire_tag_rd = 6'd33;
    tick();
    bus.retire_old_tag = 6'd5; bus.retire_arch_rd = 5'd5; bus.retire_tag_rd = 6'd34;
    tick();
    bus.retire_valid = 1'b0;
    free_m[4] = 1'b1; free_m[5] = 1'b1;
    drive(4'h8, 2, 3, 10, 32'hA5A5_0001, 1'b0, 1'b1);
    expect_accept();
    tick();
    held = observe();
    exp  = sb.pop_front();
    total++;
    if (held !== exp || held.tag_rd !== tag_t'(4)) $display("FAIL stall_pre: got %h want %h", held, exp);
    else passed++;
    bus.stall_in = 1'b1;
    drive(4'h9, 10, 1, 11, 32'hA5A5_0002, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.rename_stall !== 1'b1) $display("FAIL stall_in_stall_%0d: got %b want 1", c, bus.rename_stall);
      else passed++;
      tick();
      obs = observe();
      total++;
      if (obs !== held) $display("FAIL stall_in_hold_%0d: got %h want %h", c, obs, held);
      else passed++;
      $display("txn stall_cycle_%0d: out_valid=%b rd=%0d", c, obs.valid, obs.tag_rd);
    end
    bus.stall_in = 1'b0;
    expect_accept();
    tick();
    obs = observe();
    exp = sb.pop_front();
    total++;
    if (obs !== exp || obs.tag_rd !== tag_t'(5)) $display("FAIL stall_release: got %h want %h", obs, exp);
    else passed++;
    $display("txn stall_release: rd=%0d rs1=%0d", obs.tag_rd, obs.tag_rs1);
    drive(4'hA, 11, 10, 12, 32'h5, 1'b1, 1'b0);
    expect_accept();
    tick();
    obs = observe();
    exp = sb.pop_front();
    total++;
    if (obs !== exp) $display("FAIL stall_resume: got %h want %h", obs, exp);
    else passed++;
    $display("txn stall_resume: rs1=%0d rd=%0d", obs.tag_rs1, obs.tag_rd);
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    uop_t obs, exp;
    drive(4'h1, 1, 2, 3, 32'h7, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    #1;
    total++;
    if (observe() !== uop_t'(0)) $display("FAIL reset_midop: got %h want 0", observe());
    else passed++;
    drive(4'h1, 1, 2, 3, 32'h0, 1'b0, 1'b1);
    expect_accept();
    tick();
    obs = observe();
    exp = sb.pop_front();
    total++;
    if (obs !== exp || obs.tag_rd !== tag_t'(32)) $display("FAIL reset_realloc: got %h want %h", obs, exp);
    else passed++;
    $display("txn reset_realloc: rd=%0d old=%0d", obs.tag_rd, obs.old_tag_rd);
    bus.in_valid = 1'b0;
    tick();
  endtask

`ifdef RENAME_FLUSH_EN
  task automatic test_flush();
    uop_t obs, exp;
    // x3 already maps to 32; retire it while renaming x3 again (gets 33, no bypass of tag 3).
    drive(4'h1, 3, 1, 3, 32'h0, 1'b0, 1'b1);
    bus.retire_valid = 1'b1; bus.retire_arch_rd = 5'd3; bus.retire_tag_rd = 6'd32; bus.retire_old_tag = 6'd3;
    expect_accept();
    tick();
    bus.retire_valid = 1'b0;
    obs = observe();
    exp = sb.pop_front();
    total++;
    if (obs !== exp || obs.tag_rd !== tag_t'(33)) $display("FAIL flush_pre: got %h want %h", obs, exp);
    else passed++;
    drive(4'h2, 1, 1, 8, 32'h0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid);
    else passed++;
    for (int i = 0; i < NUM_ARCH_REGS; i++) rat_m[i] = tag_t'(i);
    rat_m[3] = tag_t'(32);
    free_m = {{(NUM_TAGS-33){1'b1}}, 1'b0, {(NUM_ARCH_REGS-4){1'b0}}, 1'b1, 3'b000};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(4'h3, 3, 3, 6, 32'h0, 1'b0, 1'b1);
      else        drive(4'h3, 6, 3, 7, 32'h0, 1'b0, 1'b1);
      expect_accept();
      tick();
      obs = observe();
      exp = sb.pop_front();
      if (k == 0) exp.tag_rd = tag_t'(3);
      else        exp.tag_rd = tag_t'(33);
      total++;
      if (obs !== exp || obs.tag_rs2 !== tag_t'(32)) $display("FAIL flush_post_%0d: got %h want %h", k, obs, exp);
      else passed++;
      $display("txn flush_post_%0d: rs2=%0d rd=%0d", k, obs.tag_rs2, obs.tag_rd);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_no_alloc();
    test_exhaust();
    test_stall_in();
    test_reset_midop();
`ifdef RENAME_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
